// File: rtl/lbp_encoder_pkg.sv
// Shared constants, types and the xorshift32 hypervector generator used to build the
// item memory (IM) and channel item memory (CIM) of the LBP window encoder.
package lbp_encoder_pkg;

  localparam int DIMENSIONS  = 10000;
  localparam int NUM_CHS     = 4;
  localparam int WINDOW_SIZE = 4;
  localparam int WINDOW_STEP = 2;
  localparam int SAMPLE_SIZE = 16;
  localparam int LBP_SIZE    = 6;
  localparam int NUM_LBP     = 2 ** LBP_SIZE;
  localparam int COUNT_SIZE  = 8;

  localparam logic [31:0] IM_SEED  = 32'h1000_0000;
  localparam logic [31:0] CIM_SEED = 32'h2000_0000;

  typedef logic [DIMENSIONS-1:0]  hv_t;
  typedef logic [LBP_SIZE-1:0]    lbp_t;
  typedef logic [SAMPLE_SIZE-1:0] sample_t;
  typedef logic [COUNT_SIZE-1:0]  cnt_t;

  // Bit i of the result is the LSB of the xorshift32 state after i+1 steps.
  function automatic hv_t gen_hv(input logic [31:0] seed);
    logic [31:0] x;
    hv_t         hv;
    x  = seed;
    hv = '0;
    for (int i = 0; i < DIMENSIONS; i++) begin
      x     = x ^ (x << 13);
      x     = x ^ (x >> 17);
      x     = x ^ (x << 5);
      hv[i] = x[0];
    end
    return hv;
  endfunction

endpackage

// File: rtl/lbp_window_encoder_majority.sv
// hv_majority: bitwise majority of N hypervectors; an exact tie takes the tie_hv bit.
// Latency: combinational; no flow control.
module hv_majority #(
  parameter int N          = 4,
  parameter int DIMENSIONS = 10000,
  parameter int COUNT_SIZE = 8
) (
  input  logic [N-1:0][DIMENSIONS-1:0] hv_in,
  input  logic [DIMENSIONS-1:0]        tie_hv,
  output logic [DIMENSIONS-1:0]        maj_hv
);

  localparam logic [COUNT_SIZE:0] N_W = (COUNT_SIZE + 1)'(N);

  logic [COUNT_SIZE-1:0] cnt;
  logic [COUNT_SIZE:0]   twice;

  // Compare 2*count against N so odd and even N share one tie rule.
  always_comb begin
    maj_hv = '0;
    cnt    = '0;
    twice  = '0;
    for (int d = 0; d < DIMENSIONS; d++) begin
      cnt = '0;
      for (int i = 0; i < N; i++) begin
        cnt = cnt + COUNT_SIZE'(hv_in[i][d]);
      end
      twice = {cnt, 1'b0};
      if (twice > N_W) begin
        maj_hv[d] = 1'b1;
      end else if (twice == N_W) begin
        maj_hv[d] = tie_hv[d];
      end
    end
  end

endmodule

// File: rtl/lbp_window_encoder.sv
// lbp_window_encoder: EEG LBP/HDC front end, done 3 edges after the accepting edge, en may assert every cycle.
// Defining LBP_ENC_CODES_OUT_EN adds the lbp_codes output (stage-1 LBP registers).
module lbp_window_encoder
  import lbp_encoder_pkg::*;
(
  input  logic                                  clk,
  input  logic                                  nrst,
  input  logic                                  en,
  input  logic [NUM_CHS-1:0][SAMPLE_SIZE-1:0]   samples,
`ifdef LBP_ENC_CODES_OUT_EN
  output logic [NUM_CHS-1:0][LBP_SIZE-1:0]      lbp_codes,
`endif
  output logic                                  done,
  output logic [DIMENSIONS-1:0]                 window_hv
);

  localparam cnt_t FILL_FULL = cnt_t'(WINDOW_SIZE);
  localparam cnt_t FILL_LAST = cnt_t'(WINDOW_SIZE - 1);
  localparam cnt_t STEP_LAST = cnt_t'(WINDOW_STEP - 1);

  // Stage 1: previous samples and LBP shift registers
  logic [NUM_CHS-1:0][SAMPLE_SIZE-1:0] prev_q, prev_d;
  logic [NUM_CHS-1:0][LBP_SIZE-1:0]    lbp_q, lbp_d;
  logic                                s1_vld_q, s1_vld_d;
  // Stage 2: registered spatial HV
  hv_t                                 spat_q, spat_d;
  logic                                s2_vld_q, s2_vld_d;
  // Stage 3: window buffer, newest at index 0
  logic [WINDOW_SIZE-1:0][DIMENSIONS-1:0] win_q, win_d;
  cnt_t                                fill_q, fill_d;
  cnt_t                                step_q, step_d;
  logic                                emit_q, emit_d;
  // Output stage
  logic                                done_q, done_d;
  hv_t                                 window_hv_q, window_hv_d;

  hv_t                                 im_rom  [NUM_LBP];
  hv_t                                 cim_rom [NUM_CHS];
  logic [NUM_CHS-1:0][DIMENSIONS-1:0]  bound;
  hv_t                                 spat_maj;
  hv_t                                 win_maj;

  for (genvar i = 0; i < NUM_LBP; i++) begin : g_im
    assign im_rom[i] = gen_hv(IM_SEED + 32'(i));
  end

  for (genvar c = 0; c < NUM_CHS; c++) begin : g_cim
    assign cim_rom[c] = gen_hv(CIM_SEED + 32'(c));
  end

  always_comb begin
    bound = '0;
    for (int c = 0; c < NUM_CHS; c++) begin
      bound[c] = im_rom[lbp_q[c]] ^ cim_rom[c];
    end
  end

  hv_majority #(
    .N          (NUM_CHS),
    .DIMENSIONS (DIMENSIONS),
    .COUNT_SIZE (COUNT_SIZE)
  ) u_spatial_maj (
    .hv_in  (bound),
    .tie_hv (bound[0]),
    .maj_hv (spat_maj)
  );

  hv_majority #(
    .N          (WINDOW_SIZE),
    .DIMENSIONS (DIMENSIONS),
    .COUNT_SIZE (COUNT_SIZE)
  ) u_window_maj (
    .hv_in  (win_q),
    .tie_hv (win_q[0]),
    .maj_hv (win_maj)
  );

  // Stage 1: a rising sample (strictly greater) shifts in a 1 at the LSB.
  always_comb begin
    prev_d   = prev_q;
    lbp_d    = lbp_q;
    s1_vld_d = en;
    if (en) begin
      for (int c = 0; c < NUM_CHS; c++) begin
        lbp_d[c]  = {lbp_q[c][LBP_SIZE-2:0], ($signed(samples[c]) > $signed(prev_q[c]))};
        prev_d[c] = samples[c];
      end
    end
  end

  always_comb begin
    spat_d   = s1_vld_q ? spat_maj : spat_q;
    s2_vld_d = s1_vld_q;
  end

  // Stage 3: emit on the push that first fills the buffer, then every WINDOW_STEP pushes.
  always_comb begin
    win_d  = win_q;
    fill_d = fill_q;
    step_d = step_q;
    emit_d = 1'b0;
    if (s2_vld_q) begin
      win_d = {win_q[WINDOW_SIZE-2:0], spat_q};
      if (fill_q == FILL_FULL) begin
        if (step_q == STEP_LAST) begin
          emit_d = 1'b1;
          step_d = '0;
        end else begin
          step_d = step_q + cnt_t'(1);
        end
      end else begin
        fill_d = fill_q + cnt_t'(1);
        if (fill_q == FILL_LAST) begin
          emit_d = 1'b1;
          step_d = '0;
        end
      end
    end
  end

  always_comb begin
    done_d      = emit_q;
    window_hv_d = emit_q ? win_maj : window_hv_q;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      prev_q      <= '0;
      lbp_q       <= '0;
      s1_vld_q    <= 1'b0;
      spat_q      <= '0;
      s2_vld_q    <= 1'b0;
      win_q       <= '0;
      fill_q      <= '0;
      step_q      <= '0;
      emit_q      <= 1'b0;
      done_q      <= 1'b0;
      window_hv_q <= '0;
    end else begin
      prev_q      <= prev_d;
      lbp_q       <= lbp_d;
      s1_vld_q    <= s1_vld_d;
      spat_q      <= spat_d;
      s2_vld_q    <= s2_vld_d;
      win_q       <= win_d;
      fill_q      <= fill_d;
      step_q      <= step_d;
      emit_q      <= emit_d;
      done_q      <= done_d;
      window_hv_q <= window_hv_d;
    end
  end

  assign done      = done_q;
  assign window_hv = window_hv_q;
`ifdef LBP_ENC_CODES_OUT_EN
  assign lbp_codes = lbp_q;
`endif

endmodule

// File: tb/tb_lbp_window_encoder.sv
// Self-checking bench for lbp_window_encoder: behavioural model plus literal timing/LBP pins.
module tb_lbp_window_encoder;
  import lbp_encoder_pkg::*;

  typedef logic [NUM_CHS-1:0][SAMPLE_SIZE-1:0] smp_t;
  typedef logic [DIMENSIONS-1:0]               vec_t;
  typedef struct { int due; vec_t hv; }        ev_t;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  logic en   = 1'b0;
  smp_t samples = '0;
  logic done;
  vec_t window_hv;
`ifdef LBP_ENC_CODES_OUT_EN
  logic [NUM_CHS-1:0][LBP_SIZE-1:0] lbp_codes;
  logic [NUM_CHS-1:0][LBP_SIZE-1:0] exp_codes;
`endif

  always #5 clk = ~clk;

  lbp_window_encoder dut (
    .clk       (clk),
    .nrst      (nrst),
    .en        (en),
    .samples   (samples),
`ifdef LBP_ENC_CODES_OUT_EN
    .lbp_codes (lbp_codes),
`endif
    .done      (done),
    .window_hv (window_hv)
  );

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   done_cnt = 0;
  int   base;
  vec_t m_im  [NUM_LBP];
  vec_t m_cim [NUM_CHS];
  int   m_prev [NUM_CHS];
  int   m_lbp  [NUM_CHS];
  vec_t m_hist [$];
  int   m_pushes;
  ev_t  m_evq [$];
  vec_t exp_win;
  int   en_cycs [$];
  int   done_cycs [$];
  smp_t s;

  function automatic vec_t ref_hv(input logic [31:0] seed);
    logic [31:0] x;
    vec_t v;
    x = seed;
    v = '0;
    for (int i = 0; i < DIMENSIONS; i++) begin
      x = x ^ (x << 13);
      x = x ^ (x >> 17);
      x = x ^ (x << 5);
      v[i] = x[0];
    end
    return v;
  endfunction

  function automatic smp_t rand_smp();
    smp_t r;
    for (int c = 0; c < NUM_CHS; c++) r[c] = SAMPLE_SIZE'($urandom);
    return r;
  endfunction

  function automatic void m_clear();
    for (int c = 0; c < NUM_CHS; c++) begin
      m_prev[c] = 0;
      m_lbp[c]  = 0;
    end
    m_hist.delete();
    m_evq.delete();
    en_cycs.delete();
    done_cycs.delete();
    m_pushes = 0;
    exp_win  = '0;
  endfunction

  // Model of one accepted sample: LBP update, spatial bundle, window bundle on emit.
  function automatic void m_accept();
    int   cnt;
    int   sv;
    vec_t sp;
    vec_t wv;
    logic b;
    ev_t  ev;
    for (int c = 0; c < NUM_CHS; c++) begin
      sv = int'($signed(samples[c]));
      m_lbp[c]  = (m_lbp[c] * 2 + ((sv > m_prev[c]) ? 1 : 0)) % NUM_LBP;
      m_prev[c] = sv;
    end
    sp = '0;
    for (int d = 0; d < DIMENSIONS; d++) begin
      cnt = 0;
      for (int c = 0; c < NUM_CHS; c++) begin
        b = m_im[m_lbp[c]][d] ^ m_cim[c][d];
        if (b) cnt++;
      end
      if (2 * cnt > NUM_CHS)       sp[d] = 1'b1;
      else if (2 * cnt == NUM_CHS) sp[d] = m_im[m_lbp[0]][d] ^ m_cim[0][d];
    end
    m_hist.push_front(sp);
    if (m_hist.size() > WINDOW_SIZE) void'(m_hist.pop_back());
    m_pushes++;
    en_cycs.push_back(cyc);
    if (m_pushes >= WINDOW_SIZE && (m_pushes - WINDOW_SIZE) % WINDOW_STEP == 0) begin
      wv = '0;
      for (int d = 0; d < DIMENSIONS; d++) begin
        cnt = 0;
        for (int k = 0; k < WINDOW_SIZE; k++) if (m_hist[k][d]) cnt++;
        if (2 * cnt > WINDOW_SIZE)       wv[d] = 1'b1;
        else if (2 * cnt == WINDOW_SIZE) wv[d] = m_hist[0][d];
      end
      ev.due = cyc + 3;
      ev.hv  = wv;
      m_evq.push_back(ev);
    end
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_hv(input string name, input vec_t act, input vec_t req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual[63:0]=%h required[63:0]=%h (cycle %0d)", name, act[63:0], req[63:0], cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (!nrst)   m_clear();
    else if (en) m_accept();
  end

  always @(negedge clk) begin : cmp
    logic ed;
    ed = 1'b0;
    if (!nrst) begin
      check("reset_done", 64'(done), 64'd0);
      check_hv("reset_window_hv", window_hv, '0);
    end else begin
      if (m_evq.size() > 0 && m_evq[0].due == cyc) begin
        ed      = 1'b1;
        exp_win = m_evq[0].hv;
        void'(m_evq.pop_front());
      end
      check("done", 64'(done), 64'(ed));
      check_hv("window_hv", window_hv, exp_win);
      if (done) begin
        done_cnt++;
        done_cycs.push_back(cyc);
      end
    end
  end

  task automatic drive(input logic e, input smp_t v);
    @(negedge clk);
    #1;
    en      = e;
    samples = v;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    nrst = 1'b0;
    en   = 1'b0;
    m_clear();
    repeat (2) @(negedge clk);
    #1;
    nrst = 1'b1;
  endtask

  task automatic check_timing(input string name, input int n);
    for (int k = 0; k < n; k++) begin
      if (done_cycs.size() > k && en_cycs.size() > WINDOW_SIZE - 1 + WINDOW_STEP * k)
        check(name, 64'(done_cycs[k]), 64'(en_cycs[WINDOW_SIZE - 1 + WINDOW_STEP * k] + 3));
      else
        check({name, "_present"}, 64'(done_cycs.size()), 64'(k + 1));
    end
  endtask

  initial begin
    for (int i = 0; i < NUM_LBP; i++) m_im[i]  = ref_hv(32'h1000_0000 + 32'(i));
    for (int c = 0; c < NUM_CHS; c++) m_cim[c] = ref_hv(32'h2000_0000 + 32'(c));
    m_clear();
    repeat (3) @(negedge clk);
`ifdef LBP_ENC_CODES_OUT_EN
    check("reset_lbp_codes", 64'(lbp_codes), 64'd0);
`endif
    #1;
    nrst = 1'b1;

    // 1: idle after reset
    base = done_cnt;
    repeat (20) drive(1'b0, rand_smp());
    check("idle_no_done", 64'(done_cnt - base), 64'd0);

    // 2: hand-computed LBP codes
    drive(1'b1, {16'h0027, 16'hFF7B, 16'hFF36, 16'hFF88});
    drive(1'b0, rand_smp());
    check("t2_s1_model_lbp3", 64'(m_lbp[3]), 64'd1);
    check("t2_s1_model_lbp0", 64'(m_lbp[0]), 64'd0);
`ifdef LBP_ENC_CODES_OUT_EN
    exp_codes = {6'd1, 6'd0, 6'd0, 6'd0};
    check("t2_s1_lbp_codes", 64'(lbp_codes), 64'(exp_codes));
`endif
    drive(1'b1, {16'h000B, 16'hFF78, 16'hFF2A, 16'hFF49});
    drive(1'b0, rand_smp());
    check("t2_s2_model_lbp3", 64'(m_lbp[3]), 64'd2);
`ifdef LBP_ENC_CODES_OUT_EN
    exp_codes = {6'd2, 6'd0, 6'd0, 6'd0};
    check("t2_s2_lbp_codes", 64'(lbp_codes), 64'(exp_codes));
`endif

    // 3: twelve sparse samples
    do_reset();
    base = done_cnt;
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, rand_smp());
      repeat (24) drive(1'b0, rand_smp());
    end
    check("t3_done_count", 64'(done_cnt - base), 64'd5);
    check_timing("t3_done_cycle", 5);

    // 4: equal consecutive samples on channel 2
    s = rand_smp();
    s[2] = 16'hFF14;
    drive(1'b1, s);
    s = rand_smp();
    s[2] = 16'hFF14;
    drive(1'b1, s);
    drive(1'b0, rand_smp());
    check("t4_model_lsb", 64'(m_lbp[2] % 2), 64'd0);
`ifdef LBP_ENC_CODES_OUT_EN
    check("t4_lbp2_lsb", 64'(lbp_codes[2][0]), 64'd0);
`endif
    repeat (6) drive(1'b0, rand_smp());

    // 5: back-to-back samples
    do_reset();
    base = done_cnt;
    for (int i = 0; i < 8; i++) drive(1'b1, rand_smp());
    repeat (10) drive(1'b0, rand_smp());
    check("t5_done_count", 64'(done_cnt - base), 64'd3);
    check_timing("t5_done_cycle", 3);

    // 6: reset drops in-flight work
    do_reset();
    for (int i = 0; i < 3; i++) drive(1'b1, rand_smp());
    do_reset();
    base = done_cnt;
    for (int i = 0; i < 3; i++) drive(1'b1, rand_smp());
    repeat (6) drive(1'b0, rand_smp());
    check_hv("t6_hv_zero", window_hv, '0);
    check("t6_no_early_done", 64'(done_cnt - base), 64'd0);
    drive(1'b1, rand_smp());
    repeat (8) drive(1'b0, rand_smp());
    check("t6_done_count", 64'(done_cnt - base), 64'd1);
    check_timing("t6_done_cycle", 1);

    // 7: random enable pattern against the model
    for (int i = 0; i < 60; i++) drive(1'($urandom_range(0, 1)), rand_smp());
    repeat (6) drive(1'b0, rand_smp());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
